// File: rtl/instr_stream_tx.sv
// Instruction-image buffer that streams 32-bit words from address 0 to a core fetch port.
// Optional running xorshift checksum of accepted beats: define INSTR_STREAM_CHECKSUM_EN.
module instr_stream_tx #(
    parameter int         DEPTH       = 256,
    parameter int         ADDR_W      = 8,
    parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic              clr,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              m_valid,
    output logic [31:0]       m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic [ADDR_W:0]   prog_len,
    output logic [ADDR_W:0]   words_sent,
`ifdef INSTR_STREAM_CHECKSUM_EN
    output logic [31:0]       checksum,
`endif
    output logic              halt_seen
);
    // Handshake: a beat transfers on a rising edge where m_valid && m_ready; while
    // m_valid is high and m_ready is low, m_data and m_last do not change.

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FETCH,
        ST_SEND,
        ST_DONE
    } state_t;

    localparam logic [ADDR_W:0]   LEN_ONE  = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE  = 1;
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] clr_ptr;
    logic [31:0]       mem [DEPTH];

    logic              cmd_ok;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic [31:0]       rd_word;
    logic [ADDR_W:0]   wr_len;
    logic [ADDR_W:0]   rd_len;

    assign cmd_ok  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign busy    = (state_q == ST_CLEAR) || (state_q == ST_FETCH) || (state_q == ST_SEND);
    assign done    = (state_q == ST_DONE);
    assign rd_word = mem[rd_ptr];
    assign wr_len  = {1'b0, wr_addr} + LEN_ONE;
    assign rd_len  = {1'b0, rd_ptr} + LEN_ONE;

    // CLEAR owns the single write port; host writes only land while idle or done.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (state_q == ST_CLEAR) begin
            mem_we    = rst_n;
            mem_waddr = clr_ptr;
            mem_wdata = '0;
        end else if (cmd_ok && wr_en) begin
            mem_we = rst_n;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rd_ptr     <= '0;
            clr_ptr    <= '0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_last     <= 1'b0;
            prog_len   <= '0;
            words_sent <= '0;
            halt_seen  <= 1'b0;
        end else begin
            if (cmd_ok && wr_en && (wr_data != '0) && (wr_len > prog_len)) begin
                prog_len <= wr_len;
            end
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (clr) begin
                        clr_ptr <= '0;
                        state_q <= ST_CLEAR;
                    end else if (start) begin
                        rd_ptr     <= '0;
                        words_sent <= '0;
                        halt_seen  <= 1'b0;
                        state_q    <= (prog_len == '0) ? ST_DONE : ST_FETCH;
                    end
                end
                ST_CLEAR: begin
                    clr_ptr <= clr_ptr + PTR_ONE;
                    if (clr_ptr == PTR_LAST) begin
                        prog_len <= '0;
                        state_q  <= ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    m_data  <= rd_word;
                    m_last  <= (rd_word[31:24] == HALT_OPCODE) || (rd_len == prog_len);
                    m_valid <= 1'b1;
                    state_q <= ST_SEND;
                end
                ST_SEND: begin
                    if (m_ready) begin
                        words_sent <= words_sent + LEN_ONE;
                        m_valid    <= 1'b0;
                        if (m_last) begin
                            halt_seen <= (m_data[31:24] == HALT_OPCODE);
                            m_last    <= 1'b0;
                            state_q   <= ST_DONE;
                        end else begin
                            rd_ptr  <= rd_ptr + PTR_ONE;
                            state_q <= ST_FETCH;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef INSTR_STREAM_CHECKSUM_EN
    logic [31:0] ck_next;

    always_comb begin
        ck_next = checksum ^ m_data;
        ck_next = ck_next ^ (ck_next << 13);
        ck_next = ck_next ^ (ck_next >> 17);
        ck_next = ck_next ^ (ck_next << 5);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (cmd_ok && !clr && start) begin
            checksum <= '0;
        end else if ((state_q == ST_SEND) && m_ready) begin
            checksum <= ck_next;
        end
    end
`endif

endmodule

// File: tb/tb_instr_stream_tx.sv
// Bench for instr_stream_tx: table of images, hand-written corner sequences and random
// images scored against a buffer/prog_len model kept in the bench.
module tb_instr_stream_tx;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              clr;
    logic              start;
    logic              busy;
    logic              done;
    logic              m_valid;
    logic [31:0]       m_data;
    logic              m_last;
    logic              m_ready;
    logic [ADDR_W:0]   prog_len;
    logic [ADDR_W:0]   words_sent;
    logic              halt_seen;
`ifdef INSTR_STREAM_CHECKSUM_EN
    logic [31:0]       checksum;
`endif

    always #5 clk = ~clk;

    instr_stream_tx #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .HALT_OPCODE(8'hFF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .clr        (clr),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .prog_len   (prog_len),
        .words_sent (words_sent),
`ifdef INSTR_STREAM_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .halt_seen  (halt_seen)
    );

    typedef struct packed {
        logic [5:0][31:0] img;
        logic [8:0]       exp_len;
        logic [8:0]       exp_beats;
        logic             exp_halt;
    } vec_t;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] shadow [DEPTH];
    int          model_len;
    logic [31:0] exp_q [$];
    int          exp_count;
    logic        exp_halt;
    logic [31:0] model_ck;
    vec_t        vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [31:0] xs(input logic [31:0] s, input logic [31:0] d);
        logic [31:0] c;
        c = s ^ d;
        c = c ^ (c << 13);
        c = c ^ (c >> 17);
        c = c ^ (c << 5);
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(a);
        wr_data = d;
        tick();
        wr_en = 1'b0;
        shadow[a] = d;
        if (d != 0 && a + 1 > model_len) model_len = a + 1;
    endtask

    task automatic do_clear();
        int cyc;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        cyc = 0;
        while (busy && cyc < 400) begin
            tick();
            cyc++;
        end
        if (busy) fail("clear_timeout");
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
        model_len = 0;
    endtask

    // Expected stream: words from 0 up to prog_len, cut after the first HALT.
    task automatic build_expect();
        exp_q.delete();
        exp_halt = 1'b0;
        for (int i = 0; i < model_len; i++) begin
            exp_q.push_back(shadow[i]);
            if (shadow[i][31:24] == 8'hFF) begin
                exp_halt = 1'b1;
                break;
            end
        end
        exp_count = exp_q.size();
        model_ck  = '0;
    endtask

    task automatic do_start();
        build_expect();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic stream(input int ready_pct, input int hold);
        logic [31:0] prev_data;
        logic        prev_stall;
        logic [31:0] e;
        int          cyc;
        prev_stall = 1'b0;
        prev_data  = '0;
        cyc        = 0;
        while (!done && cyc < 2000) begin
            if (prev_stall) begin
                check("hold_valid", 32'(m_valid), 32'd1);
                check("hold_data", m_data, prev_data);
            end
            if (m_valid && hold > 0) begin
                m_ready = 1'b0;
                hold--;
            end else begin
                m_ready = ($urandom_range(0, 99) < ready_pct);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    fail("extra_beat");
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", m_data, e);
                    check("beat_last", 32'(m_last), 32'(exp_q.size() == 0));
                    model_ck = xs(model_ck, e);
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            tick();
            cyc++;
        end
        m_ready = 1'b0;
        if (!done) fail("done_timeout");
        check("words_sent", 32'(words_sent), 32'(exp_count));
        check("halt_seen", 32'(halt_seen), 32'(exp_halt));
        check("valid_in_done", 32'(m_valid), 32'd0);
        check("missing_beats", 32'(exp_q.size()), 32'd0);
`ifdef INSTR_STREAM_CHECKSUM_EN
        check("checksum", checksum, model_ck);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int n;
        int r;
        logic [31:0] d;

        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        clr = 1'b0; start = 1'b0; m_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
        model_len = 0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", m_data, 32'd0);
        check("rst_last", 32'(m_last), 32'd0);
        check("rst_prog_len", 32'(prog_len), 32'd0);
        check("rst_words_sent", 32'(words_sent), 32'd0);
        check("rst_halt_seen", 32'(halt_seen), 32'd0);
`ifdef INSTR_STREAM_CHECKSUM_EN
        check("rst_checksum", checksum, 32'd0);
`endif
        rst_n = 1'b1;
        tick();

        // Image table: {words at addresses 0..5, prog_len, beats, halt_seen}.
        for (int v = 0; v < 5; v++) vecs[v] = '0;
        vecs[0].img[0] = 32'h0A010000; vecs[0].img[1] = 32'h0B020300; vecs[0].img[2] = 32'hFF000000;
        vecs[0].exp_len = 9'd3; vecs[0].exp_beats = 9'd3; vecs[0].exp_halt = 1'b1;
        vecs[1].img[0] = 32'h11111111; vecs[1].img[1] = 32'hFF000000; vecs[1].img[4] = 32'h22222222;
        vecs[1].exp_len = 9'd5; vecs[1].exp_beats = 9'd2; vecs[1].exp_halt = 1'b1;
        vecs[2].img[0] = 32'h01000000; vecs[2].img[1] = 32'h02000000;
        vecs[2].exp_len = 9'd2; vecs[2].exp_beats = 9'd2; vecs[2].exp_halt = 1'b0;
        vecs[3].img[5] = 32'h00000005;
        vecs[3].exp_len = 9'd6; vecs[3].exp_beats = 9'd6; vecs[3].exp_halt = 1'b0;
        vecs[4].img[0] = 32'hFF000000;
        vecs[4].exp_len = 9'd1; vecs[4].exp_beats = 9'd1; vecs[4].exp_halt = 1'b1;

        for (int v = 0; v < 5; v++) begin
            do_clear();
            for (int j = 0; j < 6; j++) write_word(j, vecs[v].img[j]);
            check("tbl_prog_len", 32'(prog_len), 32'(vecs[v].exp_len));
            do_start();
            stream(100, 0);
            check("tbl_words_sent", 32'(words_sent), 32'(vecs[v].exp_beats));
            check("tbl_halt_seen", 32'(halt_seen), 32'(vecs[v].exp_halt));
            check("tbl_done", 32'(done), 32'd1);
            if (v == 2) begin
                do_start();
                stream(100, 0);
                check("restart_words_sent", 32'(words_sent), 32'd2);
            end
        end
`ifdef INSTR_STREAM_CHECKSUM_EN
        check("single_halt_checksum", checksum, xs(32'd0, 32'hFF000000));
`endif

        // Backpressure: first beat stalled for 4 cycles.
        do_clear();
        for (int j = 0; j < 3; j++) write_word(j, vecs[0].img[j]);
        do_start();
        stream(100, 4);

        // start with an empty image finishes immediately with no beats.
        do_clear();
        build_expect();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("empty_done", 32'(done), 32'd1);
        check("empty_valid", 32'(m_valid), 32'd0);
        check("empty_busy", 32'(busy), 32'd0);
        check("empty_words_sent", 32'(words_sent), 32'd0);
        check("empty_halt_seen", 32'(halt_seen), 32'd0);

        // clr and start together: clear wins, start held high is ignored throughout.
        write_word(3, 32'h00001234);
        check("pre_clear_prog_len", 32'(prog_len), 32'd4);
        clr = 1'b1;
        start = 1'b1;
        tick();
        clr = 1'b0;
        cyc = 0;
        while (busy && cyc < 400) begin
            if (m_valid) fail("valid_during_clear");
            cyc++;
            tick();
        end
        start = 1'b0;
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
        model_len = 0;
        check("clear_cycles", 32'(cyc), 32'd256);
        check("clear_prog_len", 32'(prog_len), 32'd0);
        check("clear_done", 32'(done), 32'd0);
        tick();
        check("clear_no_start", 32'(busy), 32'd0);

        // Reset mid-stream after one accepted beat.
        for (int j = 0; j < 3; j++) write_word(j, vecs[0].img[j]);
        do_start();
        m_ready = 1'b1;
        cyc = 0;
        while (words_sent != 1 && cyc < 20) begin
            tick();
            cyc++;
        end
        m_ready = 1'b0;
        cyc = 0;
        while (!m_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        if (!m_valid) fail("second_beat_timeout");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_len = 0;
        check("midrst_valid", 32'(m_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_words_sent", 32'(words_sent), 32'd0);
        check("midrst_prog_len", 32'(prog_len), 32'd0);
`ifdef INSTR_STREAM_CHECKSUM_EN
        check("midrst_checksum", checksum, 32'd0);
`endif
        m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("midrst_quiet", 32'(m_valid), 32'd0);
        end
        m_ready = 1'b0;
        do_start();
        stream(100, 0);

        // Random images accumulated across runs, periodically cleared.
        for (int it = 0; it < 16; it++) begin
            if (it % 4 == 0) do_clear();
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                r = $urandom_range(0, 5);
                if (r == 0)      d = '0;
                else if (r == 1) d = {8'hFF, 24'($urandom)};
                else             d = $urandom;
                write_word($urandom_range(0, 11), d);
            end
            check("rnd_prog_len", 32'(prog_len), 32'(model_len));
            do_start();
            stream($urandom_range(30, 100), $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                do_start();
                stream($urandom_range(30, 100), 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
